team_gpio_arbiter: RTL and testbench

//   Shares the 34 user GPIO pads (mprj_io[37:5], mprj_io[0]) among N_REQ team cores.

---
 rtl/team_gpio_arbiter_if.sv | 29 ++
 rtl/team_gpio_arbiter.sv | 115 +++++++++++
 tb/tb_team_gpio_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/team_gpio_arbiter_if.sv
// Pad-bank sharing bus between team cores (master side) and the GPIO arbiter (slave side).
// Per-core out/oeb are packed core i at [i*IO_W +: IO_W]; gnt/owner_id/busy/preempt come back registered.
interface team_gpio_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int IO_W  = 34
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic                    en;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*IO_W-1:0]   out_i;
   logic [N_REQ*IO_W-1:0]   oeb_i;
   logic [N_REQ-1:0]        gnt;
   logic [IO_W-1:0]         io_out;
   logic [IO_W-1:0]         io_oeb;
   logic [IDW-1:0]          owner_id;
   logic                    busy;
   logic                    preempt;

   modport master (
      output en, req, out_i, oeb_i,
      input  gnt, io_out, io_oeb, owner_id, busy, preempt
   );

   modport slave (
      input  en, req, out_i, oeb_i,
      output gnt, io_out, io_oeb, owner_id, busy, preempt
   );
endinterface

// File: rtl/team_gpio_arbiter.sv
// Round-robin lease arbiter muxing one core's out/oeb onto the shared pads; grant 1 cycle after req, 2-cycle handover bubble.
// GPIO_ARB_TIMEOUT_EN adds a HOLD_MAX lease counter that revokes ownership when another core is waiting.
module team_gpio_arbiter #(
   parameter int N_REQ    = 4,
   parameter int IO_W     = 34,
   parameter int HOLD_MAX = 1024
) (
   input  logic                  clk,
   input  logic                  nrst,
   team_gpio_arbiter_if.slave    bus
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_REQ-1:0]   r_gnt;
   logic [IDW-1:0]     r_owner;
   logic [IDW-1:0]     r_ptr;
   logic               r_busy;
   logic               r_preempt;

   logic [IDW:0]       w_idx;
   logic [IDW-1:0]     w_win;
   logic               w_found;
   logic               w_others;
   logic               w_expired;
   logic               w_revoke;

   // First requester at or after the RR pointer, wrapping at N_REQ.
   always_comb begin
      w_idx   = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
         if (w_idx >= (IDW+1)'(N_REQ)) w_idx = w_idx - (IDW+1)'(N_REQ);
         if (!w_found && bus.req[w_idx[IDW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[IDW-1:0];
         end
      end
   end

   assign w_others = |(bus.req & ~r_gnt);

`ifdef GPIO_ARB_TIMEOUT_EN
   localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                                            r_cnt <= '0;
      else if (r_state != OWNED)                            r_cnt <= '0;
      else if (r_cnt != CW'(HOLD_MAX-1))                    r_cnt <= r_cnt + 1'b1;
   end

   assign w_expired = (r_cnt == CW'(HOLD_MAX-1));
`else
   assign w_expired = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_revoke    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.en && w_found) w_state_nxt = OWNED;
         end
         OWNED: begin
            if (!bus.en || !bus.req[r_owner]) begin
               w_state_nxt = DRAIN;
            end else if (w_expired && w_others) begin
               w_state_nxt = DRAIN;
               w_revoke    = 1'b1;
            end
         end
         DRAIN:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_busy    <= 1'b0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_preempt <= w_revoke;
         if (r_state == IDLE && w_state_nxt == OWNED) begin
            r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            r_owner <= w_win;
            r_busy  <= 1'b1;
         end else if (r_state == OWNED && w_state_nxt == DRAIN) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
         end
         // The departing owner ranks last in the next arbitration.
         if (r_state == DRAIN) begin
            r_ptr <= (r_owner == IDW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
         end
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.owner_id = r_owner;
   assign bus.busy     = r_busy;
   assign bus.preempt  = r_preempt;
   assign bus.io_out   = r_busy ? bus.out_i[r_owner*IO_W +: IO_W] : '0;
   assign bus.io_oeb   = r_busy ? bus.oeb_i[r_owner*IO_W +: IO_W] : '1;
endmodule

// File: tb/tb_team_gpio_arbiter.sv
// Scoreboarded bench for team_gpio_arbiter: expected grants queued at stimulus time, popped on each new grant.
// Build with or without GPIO_ARB_TIMEOUT_EN; the lease test adapts to the build.
module tb_team_gpio_arbiter;
   localparam int N  = 4;
   localparam int W  = 34;
   localparam int HM = 16;

   logic clk;
   logic nrst;

   team_gpio_arbiter_if #(.N_REQ(N), .IO_W(W)) arb_if ();

   team_gpio_arbiter #(.N_REQ(N), .IO_W(W), .HOLD_MAX(HM)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (arb_if)
   );

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [3:0] sb_q[$];
   logic [3:0] prev_gnt = '0;
   int         gap = 100;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string tag, input logic [3:0] g);
      int n = 0;
      while (arb_if.gnt !== g && n < 200) begin
         tick(1);
         n++;
      end
      chk(tag, arb_if.gnt, g);
   endtask

   // Scoreboard: every fresh grant must match the next queued expectation and follow a >=2 cycle gap.
   always @(negedge clk) begin
      logic [3:0] e;
      if (arb_if.gnt != 0 && prev_gnt == 0) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", arb_if.gnt, 0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_gnt", arb_if.gnt, e);
            chk("gap_ge2", (gap >= 2), 1);
         end
      end
      if (arb_if.gnt == 0) gap++;
      else                 gap = 0;
      prev_gnt = arb_if.gnt;
   end

   initial begin
      int bad;
      logic [3:0] g;
      logic [3:0] r;

      // 1: reset with everyone requesting
      nrst = 1'b0;
      arb_if.en    = 1'b1;
      arb_if.req   = 4'b1111;
      arb_if.out_i = '0;
      arb_if.oeb_i = '1;
      arb_if.out_i[0*W +: W] = 34'h0_AAAA_5555;
      arb_if.oeb_i[0*W +: W] = 34'h0_0000_FFFF;
      arb_if.out_i[1*W +: W] = 34'h2_1111_2222;
      arb_if.out_i[2*W +: W] = 34'h1_2345_6789;
      arb_if.oeb_i[2*W +: W] = '0;
      arb_if.out_i[3*W +: W] = 34'h3_CAFE_BEEF;
      tick(2);
      chk("rst_gnt", arb_if.gnt, 0);
      chk("rst_oeb", arb_if.io_oeb, 34'h3_FFFF_FFFF);
      chk("rst_out", arb_if.io_out, 0);
      chk("rst_busy", arb_if.busy, 0);
      chk("rst_preempt", arb_if.preempt, 0);
      chk("rst_owner", arb_if.owner_id, 0);
      sb_q.push_back(4'b0001);
      nrst = 1'b1;
      tick(2);
      chk("t1_gnt", arb_if.gnt, 4'b0001);
      chk("t1_out", arb_if.io_out, 34'h0_AAAA_5555);
      chk("t1_oeb", arb_if.io_oeb, 34'h0_0000_FFFF);

      // 2: single owner core 2, then voluntary release
      sb_q.push_back(4'b0100);
      arb_if.req = 4'b0100;
      wait_gnt("t2_wait", 4'b0100);
      chk("t2_owner", arb_if.owner_id, 2);
      chk("t2_busy", arb_if.busy, 1);
      chk("t2_out", arb_if.io_out, 34'h1_2345_6789);
      chk("t2_oeb", arb_if.io_oeb, 0);
      arb_if.req = 4'b0000;
      tick(1);
      chk("t2_drain_oeb", arb_if.io_oeb, 34'h3_FFFF_FFFF);
      chk("t2_drain_out", arb_if.io_out, 0);
      chk("t2_drain_busy", arb_if.busy, 0);
      tick(2);
      chk("t2_idle_gnt", arb_if.gnt, 0);

      // 3: round robin from a fresh pointer, each owner holds 10 cycles
      nrst = 1'b0;
      tick(1);
      nrst = 1'b1;
      sb_q.push_back(4'b0001);
      sb_q.push_back(4'b0010);
      sb_q.push_back(4'b0100);
      sb_q.push_back(4'b1000);
      sb_q.push_back(4'b0001);
      arb_if.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         bad = 0;
         while (arb_if.gnt == 0 && bad < 50) begin
            tick(1);
            bad++;
         end
         chk("t3_granted", (arb_if.gnt != 0), 1);
         g = arb_if.gnt;
         tick(10);
         r = 4'b1111 & ~g;
         arb_if.req = r;
         tick(1);
         arb_if.req = (i == 4) ? 4'b0000 : 4'b1111;
      end
      tick(3);

      // 4: lease timeout with core 3 contending
      sb_q.push_back(4'b0010);
      arb_if.req = 4'b0010;
      wait_gnt("t4_wait", 4'b0010);
      tick(4);
      arb_if.req = 4'b1010;
`ifdef GPIO_ARB_TIMEOUT_EN
      sb_q.push_back(4'b1000);
      tick(11);
      chk("t4_last_owned_gnt", arb_if.gnt, 4'b0010);
      chk("t4_no_early_preempt", arb_if.preempt, 0);
      tick(1);
      chk("t4_preempt", arb_if.preempt, 1);
      chk("t4_drain_gnt", arb_if.gnt, 0);
      tick(1);
      chk("t4_preempt_pulse", arb_if.preempt, 0);
      tick(1);
      chk("t4_new_gnt", arb_if.gnt, 4'b1000);
`else
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (arb_if.gnt !== 4'b0010 || arb_if.preempt !== 1'b0) bad++;
      end
      chk("t4_hold_1000", bad, 0);
`endif
      arb_if.req = 4'b0000;
      tick(4);

      // 5: lone owner across several leases
      sb_q.push_back(4'b0001);
      arb_if.req = 4'b0001;
      wait_gnt("t5_wait", 4'b0001);
      bad = 0;
      for (int i = 0; i < 3*HM; i++) begin
         tick(1);
         if (arb_if.gnt !== 4'b0001 || arb_if.preempt !== 1'b0) bad++;
      end
      chk("t5_no_preempt", bad, 0);
      arb_if.req = 4'b0000;
      tick(4);

      // 6a: en dropped mid-lease; pointer must survive the pause
      sb_q.push_back(4'b0010);
      arb_if.req = 4'b0010;
      wait_gnt("t6_wait", 4'b0010);
      tick(3);
      arb_if.en = 1'b0;
      tick(1);
      chk("t6_en_drain_gnt", arb_if.gnt, 0);
      chk("t6_en_drain_oeb", arb_if.io_oeb, 34'h3_FFFF_FFFF);
      arb_if.req = 4'b0011;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (arb_if.gnt !== 4'b0000) bad++;
      end
      chk("t6_no_gnt_en0", bad, 0);
      sb_q.push_back(4'b0001);
      arb_if.en = 1'b1;
      wait_gnt("t6_ptr_kept", 4'b0001);

      // 6b: asynchronous reset mid-lease
      tick(3);
      #2;
      nrst = 1'b0;
      #1;
      chk("t6_rst_gnt", arb_if.gnt, 0);
      chk("t6_rst_oeb", arb_if.io_oeb, 34'h3_FFFF_FFFF);
      chk("t6_rst_out", arb_if.io_out, 0);
      chk("t6_rst_busy", arb_if.busy, 0);
      chk("t6_rst_owner", arb_if.owner_id, 0);
      arb_if.req = 4'b0000;
      tick(1);
      nrst = 1'b1;
      tick(3);
      chk("t6_post_gnt", arb_if.gnt, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
